// File: rtl/iob_eth_tx_framer_pkg.sv
// Shared constants and helpers for the Ethernet TX framer.
// Frame layout constants, FSM state codes and the header byte lookup.
package iob_eth_tx_framer_pkg;

   localparam int PREAMBLE_LEN = 7;
   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE = 8'hD5;
   localparam int HDR_LEN = 14;
   localparam int FRAME_HDR_LEN = PREAMBLE_LEN + 1 + HDR_LEN;
   localparam int MIN_NBYTES = 68;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HDR     = 3'd1;
   localparam logic [2:0] ST_PAYLOAD = 3'd2;
   localparam logic [2:0] ST_PAD     = 3'd3;
   localparam logic [2:0] ST_ARM     = 3'd4;
   localparam logic [2:0] ST_WAIT_LO = 3'd5;
   localparam logic [2:0] ST_WAIT_HI = 3'd6;

   // Byte idx of the preamble/SFD/MAC/type prefix, first wire byte at idx 0.
   function automatic logic [7:0] hdr_byte(
      input logic [4:0]  idx,
      input logic [47:0] dst,
      input logic [47:0] src,
      input logic [15:0] typ
   );
      logic [175:0] img;
      img = {{PREAMBLE_LEN{PREAMBLE_BYTE}}, SFD_BYTE, dst, src, typ};
      if (idx < 5'(FRAME_HDR_LEN))
         return img[(FRAME_HDR_LEN - 1 - int'(idx)) * 8 +: 8];
      return 8'h00;
   endfunction

endpackage

// File: rtl/iob_eth_tx_ram.sv
// Frame buffer: one write port, one registered read port.
// Same-address read during a write returns the old byte.
module iob_eth_tx_ram #(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [0:(2**AW)-1];

   // Write port.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // Registered read port, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst)
         rdata <= 8'h00;
      else
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/iob_eth_tx_framer.sv
// Ethernet TX framer: builds preamble+header+payload+pad in a buffer,
// then hands it to the MII transmitter with send/nbytes/ready.
module iob_eth_tx_framer
   import iob_eth_tx_framer_pkg::*;
#(
   parameter int BUF_AW      = 11,
   parameter int MAX_PAYLOAD = 1500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [47:0] dst_mac,
   input  logic [47:0] src_mac,
   input  logic [15:0] eth_type,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic        tx_send,
   output logic [10:0] tx_nbytes,
   input  logic        tx_ready,
   input  logic [10:0] tx_addr,
   output logic [7:0]  tx_data,
   output logic        frame_done,
   output logic        err_oversize
);

   localparam int PW = $clog2(MAX_PAYLOAD + 1);
   localparam logic [PW-1:0] PMAX = PW'(MAX_PAYLOAD);
   localparam logic [BUF_AW-1:0] HDR_END = BUF_AW'(FRAME_HDR_LEN - 1);
   localparam logic [BUF_AW-1:0] MIN_N = BUF_AW'(MIN_NBYTES);
   localparam logic [BUF_AW-1:0] MIN_END = BUF_AW'(MIN_NBYTES - 1);

   logic [2:0]        state;
   logic [BUF_AW-1:0] wptr;
   logic [PW-1:0]     pcnt;
   logic              ovf;
   logic [47:0]       dst_q;
   logic [47:0]       src_q;
   logic [15:0]       type_q;
   logic              hs;
   logic              keep;
   logic              we;
   logic [7:0]        wdata;

   assign s_ready = (state == ST_PAYLOAD);
   assign hs = s_valid & s_ready;
   // pcnt saturates at PMAX; further bytes are swallowed
   assign keep = (pcnt != PMAX);

   // Select the byte written at wptr this cycle.
   always_comb begin
      we = 1'b0;
      wdata = 8'h00;
      case (state)
         ST_HDR: begin
            we = 1'b1;
            wdata = hdr_byte(wptr[4:0], dst_q, src_q, type_q);
         end
         ST_PAYLOAD: begin
            we = hs & keep;
            wdata = s_data;
         end
         ST_PAD: begin
            we = 1'b1;
            wdata = 8'h00;
         end
         default: begin
            we = 1'b0;
            wdata = 8'h00;
         end
      endcase
   end

   // Frame build and handover sequencing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         wptr <= '0;
         pcnt <= '0;
         ovf <= 1'b0;
         dst_q <= '0;
         src_q <= '0;
         type_q <= '0;
         tx_send <= 1'b0;
         tx_nbytes <= '0;
         frame_done <= 1'b0;
         err_oversize <= 1'b0;
      end else begin
         tx_send <= 1'b0;
         frame_done <= 1'b0;
         err_oversize <= 1'b0;
         if (we)
            wptr <= wptr + BUF_AW'(1);
         case (state)
            ST_IDLE: begin
               if (s_valid) begin
                  dst_q <= dst_mac;
                  src_q <= src_mac;
                  type_q <= eth_type;
                  wptr <= '0;
                  pcnt <= '0;
                  ovf <= 1'b0;
                  state <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (wptr == HDR_END)
                  state <= ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               if (hs) begin
                  if (keep) begin
                     pcnt <= pcnt + PW'(1);
                  end else if (!ovf) begin
                     ovf <= 1'b1;
                     err_oversize <= 1'b1;
                  end
                  if (s_last) begin
                     if ((wptr + BUF_AW'(keep)) < MIN_N)
                        state <= ST_PAD;
                     else
                        state <= ST_ARM;
                  end
               end
            end
            ST_PAD: begin
               if (wptr == MIN_END)
                  state <= ST_ARM;
            end
            ST_ARM: begin
               tx_nbytes <= 11'(wptr);
               if (tx_ready) begin
                  tx_send <= 1'b1;
                  state <= ST_WAIT_LO;
               end
            end
            ST_WAIT_LO: begin
               if (!tx_ready)
                  state <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (tx_ready) begin
                  frame_done <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   iob_eth_tx_ram #(
      .AW(BUF_AW)
   ) u_ram (
      .clk(clk),
      .rst(rst),
      .we(we),
      .waddr(wptr),
      .wdata(wdata),
      .raddr(BUF_AW'(tx_addr)),
      .rdata(tx_data)
   );

endmodule

// File: tb/tb_iob_eth_tx_framer.sv
// Self-checking bench for iob_eth_tx_framer.
// Frame images are predicted from layout rules and read back via tx_addr.
module tb_iob_eth_tx_framer;

   logic        clk = 1'b0;
   logic        rst;
   logic [47:0] dst_mac;
   logic [47:0] src_mac;
   logic [15:0] eth_type;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic        tx_send;
   logic [10:0] tx_nbytes;
   logic        tx_ready;
   logic [10:0] tx_addr;
   logic [7:0]  tx_data;
   logic        frame_done;
   logic        err_oversize;

   always #5 clk = ~clk;

   iob_eth_tx_framer dut (
      .clk(clk),
      .rst(rst),
      .dst_mac(dst_mac),
      .src_mac(src_mac),
      .eth_type(eth_type),
      .s_data(s_data),
      .s_valid(s_valid),
      .s_last(s_last),
      .s_ready(s_ready),
      .tx_send(tx_send),
      .tx_nbytes(tx_nbytes),
      .tx_ready(tx_ready),
      .tx_addr(tx_addr),
      .tx_data(tx_data),
      .frame_done(frame_done),
      .err_oversize(err_oversize)
   );

   logic [7:0] pl [0:1599];
   logic [7:0] exp_mem [0:2047];
   logic [7:0] got [0:2047];
   logic [7:0] refb [0:67];
   int exp_len;
   int errors = 0;
   int checks = 0;
   int last_cycles;
   int err_seen;
   int err_at;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  name, act, req, $time);
      end
   endtask

   // Expected frame image from the layout rules.
   task automatic build_exp(input int n);
      int kept;
      kept = (n < 1500) ? n : 1500;
      exp_len = (22 + kept < 68) ? 68 : 22 + kept;
      for (int k = 0; k < exp_len; k++) begin
         if (k < 7) exp_mem[k] = 8'h55;
         else if (k == 7) exp_mem[k] = 8'hD5;
         else if (k < 14) exp_mem[k] = dst_mac[8*(13-k) +: 8];
         else if (k < 20) exp_mem[k] = src_mac[8*(19-k) +: 8];
         else if (k < 22) exp_mem[k] = eth_type[8*(21-k) +: 8];
         else if (k < 22 + kept) exp_mem[k] = pl[k-22];
         else exp_mem[k] = 8'h00;
      end
   endtask

   task automatic send_payload(input int n, input bit gaps,
                               input int abort_at);
      int i = 0;
      int cyc = 0;
      err_seen = 0;
      err_at = -1;
      while (i < n && cyc < 4 * n + 100) begin
         @(negedge clk);
         cyc++;
         if (err_oversize === 1'b1) begin
            err_seen++;
            err_at = i - 1;
         end
         if (abort_at >= 0 && i == abort_at) begin
            rst = 1'b1;
            s_valid = 1'b0;
            s_last = 1'b0;
            last_cycles = cyc;
            return;
         end
         if (gaps && $urandom_range(0, 2) == 0) begin
            s_valid = 1'b0;
            s_last = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data = pl[i];
            s_last = (i == n - 1);
            if (s_ready === 1'b1) i++;
         end
      end
      chk("payload_accepted", i, n);
      last_cycles = cyc;
      @(negedge clk);
      if (err_oversize === 1'b1) begin
         err_seen++;
         err_at = i - 1;
      end
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask

   // Transmitter model: waits for send, reads the frame, returns ready.
   task automatic tx_phase(input int busy, input int hold);
      int t;
      bit seen;
      int total;
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("send_while_not_ready", tx_send, 0);
            chk("s_ready_arm", s_ready, 0);
         end
         chk("tx_nbytes_armed", tx_nbytes, exp_len);
         tx_ready = 1'b1;
      end
      t = 0;
      seen = 1'b0;
      while (!seen && t < 400) begin
         @(negedge clk);
         t++;
         chk("s_ready_pre_send", s_ready, 0);
         if (tx_send === 1'b1) seen = 1'b1;
      end
      chk("tx_send_seen", seen, 1);
      if (!seen) return;
      chk("tx_nbytes", tx_nbytes, exp_len);
      total = (exp_len + 1 > busy) ? exp_len + 1 : busy;
      for (int c = 0; c < total; c++) begin
         @(negedge clk);
         if (c == 0) tx_ready = 1'b0;
         if (c >= 1 && c <= exp_len) begin
            got[c-1] = tx_data;
            chk("tx_data", tx_data, exp_mem[c-1]);
         end
         if (c < exp_len) tx_addr = 11'(c);
         chk("tx_send_pulse", tx_send, 0);
         chk("s_ready_busy", s_ready, 0);
         chk("frame_done_early", frame_done, 0);
         chk("err_oversize_busy", err_oversize, 0);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      chk("frame_done", frame_done, 1);
      @(negedge clk);
      chk("frame_done_pulse", frame_done, 0);
      chk("s_ready_idle", s_ready, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_tx_send"}, tx_send, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_err_oversize"}, err_oversize, 0);
      chk({tag, "_tx_nbytes"}, tx_nbytes, 0);
      chk({tag, "_tx_data"}, tx_data, 0);
   endtask

   initial begin
      rst = 1'b1;
      s_valid = 1'b0;
      s_data = 8'h00;
      s_last = 1'b0;
      tx_ready = 1'b1;
      tx_addr = '0;
      dst_mac = 48'hFFFF_FFFF_FFFF;
      src_mac = 48'h0200_0000_0001;
      eth_type = 16'h0800;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;

      // 1: single byte, padded
      pl[0] = 8'hAB;
      build_exp(1);
      send_payload(1, 1'b0, -1);
      chk("hdr_latency_1", last_cycles, 24);
      tx_phase(0, 0);
      chk("f1_nbytes", tx_nbytes, 68);
      chk("f1_b0", got[0], 8'h55);
      chk("f1_b6", got[6], 8'h55);
      chk("f1_b7", got[7], 8'hD5);
      chk("f1_b8", got[8], 8'hFF);
      chk("f1_b14", got[14], 8'h02);
      chk("f1_b19", got[19], 8'h01);
      chk("f1_b20", got[20], 8'h08);
      chk("f1_b21", got[21], 8'h00);
      chk("f1_b22", got[22], 8'hAB);
      chk("f1_b67", got[67], 8'h00);

      // 2: exact minimum, then 100 bytes
      dst_mac = 48'h0011_2233_4455;
      src_mac = 48'hA0B1_C2D3_E4F5;
      eth_type = 16'h86DD;
      for (int i = 0; i < 100; i++) pl[i] = 8'(i);
      build_exp(46);
      send_payload(46, 1'b0, -1);
      chk("hdr_latency_46", last_cycles, 69);
      tx_phase(0, 0);
      chk("f2a_nbytes", tx_nbytes, 68);
      chk("f2a_b67", got[67], 8'h2D);
      build_exp(100);
      send_payload(100, 1'b0, -1);
      tx_phase(0, 0);
      chk("f2b_nbytes", tx_nbytes, 122);
      chk("f2b_b121", got[121], 8'h63);

      // 3: oversize
      for (int i = 0; i < 1600; i++) pl[i] = 8'(i);
      build_exp(1600);
      send_payload(1600, 1'b0, -1);
      chk("over_cycles", last_cycles, 1623);
      chk("over_pulses", err_seen, 1);
      chk("over_index", err_at, 1500);
      tx_phase(0, 0);
      chk("f3_nbytes", tx_nbytes, 1522);
      chk("f3_b1521", got[1521], 8'hDB);

      // 4: transmitter busy on entry to ARM, long transmit
      for (int i = 0; i < 5; i++) pl[i] = 8'(8'hE0 + i);
      tx_ready = 1'b0;
      build_exp(5);
      send_payload(5, 1'b0, -1);
      tx_phase(300, 100);

      // 5: reset mid-payload
      tx_addr = 11'd7;
      for (int i = 0; i < 20; i++) pl[i] = 8'(8'h30 + i);
      send_payload(20, 1'b0, 10);
      @(negedge clk);
      chk_reset_outputs("midrst");
      rst = 1'b0;
      pl[0] = 8'h5A;
      build_exp(1);
      send_payload(1, 1'b0, -1);
      tx_phase(0, 0);
      chk("f5_b22", got[22], 8'h5A);
      chk("f5_nbytes", tx_nbytes, 68);

      // 6: gaps versus gap-free
      dst_mac = 48'h1234_5678_9ABC;
      src_mac = 48'hDEAD_BEEF_0042;
      eth_type = 16'h88B5;
      for (int i = 0; i < 30; i++) pl[i] = 8'(i * 7 + 3);
      build_exp(30);
      send_payload(30, 1'b0, -1);
      tx_phase(0, 0);
      for (int k = 0; k < 68; k++) refb[k] = got[k];
      send_payload(30, 1'b1, -1);
      tx_phase(0, 0);
      for (int k = 0; k < 68; k++) chk("gap_vs_ref", got[k], refb[k]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
